// File: rtl/morse_elem_sequencer.sv
// Walks mux slots 0..15 and turns each element code into a timed on/off key signal.
// All outputs registered; start is honoured only in IDLE, abort wins over everything except reset.
module morse_elem_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] sym,
    output logic [3:0] sel,
    output logic       key_out,
    output logic       busy,
    output logic       done
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MARK,
        S_SPACE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_units;

    logic w_wrap;
    logic w_last;

    assign w_wrap = (r_tick == TICK_LAST);
    assign w_last = w_wrap && (r_units == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_units <= '0;
            sel     <= '0;
            key_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_units <= '0;
            sel     <= '0;
            key_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_tick <= '0;
                    case (sym)
                        3'b001: begin
                            r_state <= S_MARK;
                            r_units <= 3'd1;
                            key_out <= 1'b1;
                        end
                        3'b010: begin
                            r_state <= S_MARK;
                            r_units <= 3'd3;
                            key_out <= 1'b1;
                        end
                        // Gaps skip the mark and its trailing auto-space entirely.
                        3'b011: begin
                            r_state <= S_SPACE;
                            r_units <= 3'd2;
                        end
                        3'b100: begin
                            r_state <= S_SPACE;
                            r_units <= 3'd6;
                        end
                        default: begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    endcase
                end
                S_MARK: begin
                    r_tick <= w_wrap ? '0 : r_tick + TW'(1);
                    if (w_last) begin
                        r_state <= S_SPACE;
                        r_units <= 3'd1;
                        key_out <= 1'b0;
                    end else if (w_wrap) begin
                        r_units <= r_units - 3'd1;
                    end
                end
                S_SPACE: begin
                    r_tick <= w_wrap ? '0 : r_tick + TW'(1);
                    if (w_last) begin
                        r_units <= '0;
                        if (sel == 4'd15) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            sel     <= sel + 4'd1;
                        end
                    end else if (w_wrap) begin
                        r_units <= r_units - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    sel     <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    sel     <= '0;
                    key_out <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_morse_elem_sequencer.sv
// Scoreboarded bench: a slot-level model expands each message into its expected per-cycle trace.
module tb_morse_elem_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] sym;
    logic [3:0] sel;
    logic       key_out;
    logic       busy;
    logic       done;

    logic [2:0] slots [16];
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;

    typedef struct packed {
        logic [3:0] sel;
        logic       key;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;

    always #5 clk = ~clk;

    // Combinational model of the 16:1 symbol mux.
    assign sym = slots[sel];

    morse_elem_sequencer #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .sym     (sym),
        .sel     (sel),
        .key_out (key_out),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input int s, input bit k, input bit d, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sel  = 4'(s);
            e.key  = k;
            e.done = d;
            exp_q.push_back(e);
        end
    endtask

    // Each slot costs one fetch cycle, then mark+auto-space, a gap, or the done cycle.
    task automatic model();
        bit ended = 1'b0;
        for (int s = 0; s < 16 && !ended; s++) begin
            push(s, 1'b0, 1'b0, 1);
            case (int'(slots[s]))
                1: begin push(s, 1'b1, 1'b0, TD);     push(s, 1'b0, 1'b0, TD); end
                2: begin push(s, 1'b1, 1'b0, 3 * TD); push(s, 1'b0, 1'b0, TD); end
                3: push(s, 1'b0, 1'b0, 2 * TD);
                4: push(s, 1'b0, 1'b0, 6 * TD);
                default: begin push(s, 1'b0, 1'b1, 1); ended = 1'b1; end
            endcase
        end
        if (!ended) push(15, 1'b0, 1'b1, 1);
    endtask

    task automatic load(input string codes);
        for (int i = 0; i < 16; i++) slots[i] = 3'd0;
        for (int i = 0; i < codes.len() && i < 16; i++) slots[i] = 3'(codes[i] - "0");
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("busy_without_expectation", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("sel", int'(sel), int'(m_e.sel));
                    chk("key_out", int'(key_out), int'(m_e.key));
                    chk("done", int'(done), int'(m_e.done));
                end
            end else begin
                chk("idle_key_out", int'(key_out), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_sel", int'(sel), 0);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
            start = busy && ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        chk("finish_in_budget", int'(n < budget), 1);
    endtask

    task automatic kick();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic run_msg();
        model();
        kick();
        wait_idle(2000);
        @(posedge clk); #1;
        chk("trace_consumed", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_key(input int budget);
        int n = 0;
        while (!key_out && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("key_seen", int'(key_out), 1);
    endtask

    task automatic random_slots();
        int r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      slots[i] = 3'd0;
            else if (r == 1) slots[i] = 3'($urandom_range(5, 7));
            else             slots[i] = 3'($urandom_range(1, 4));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        load("");
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", int'(sel), 0);
        chk("reset_key_out", int'(key_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        load("10");
        run_msg();
        load("111322231110");
        run_msg();
        load("1111111111111111");
        run_msg();
        load("116");
        run_msg();

        // start and abort together in IDLE: abort wins
        load("1");
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", int'(busy), 0);

        // abort in the middle of a dash
        load("21");
        model();
        kick();
        wait_key(20);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_key_out", int'(key_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sel", int'(sel), 0);
        chk("abort_done", int'(done), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        load("2134");
        run_msg();

        // asynchronous reset during a mark
        load("21");
        model();
        kick();
        wait_key(20);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_key_out", int'(key_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        chk("rst_held_busy", int'(busy), 0);
        rst_n = 1'b1;
        exp_q.delete();
        load("12");
        run_msg();

        for (int m = 0; m < 12; m++) begin
            random_slots();
            run_msg();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/morse_elem_sequencer.md
# morse_elem_sequencer

Sequencer that drives the 4-bit select of the 16:1, 3-bit symbol mux in the Morse transmitter and converts each selected 3-bit element code into a timed on/off key signal. It walks the symbol slots from 0 upward, holds the key high or low for the number of dot-units the code demands, inserts the inter-element gap automatically, and stops on an END code or after slot 15. It sits between the mux and the transmitter output stage (LED/buzzer driver).

## Interface
- TICK_DIV, 4, clock cycles per Morse dot-unit; must be ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a message; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE on the next edge from any state.
- sym  input  3  element code from the mux output for the current `sel`.
- sel  output  4  slot select to the mux.
- key_out  output  1  transmitter key: 1 = tone/light on.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a message completes normally (not on abort).

## Operation
- Element codes: 000 END; 001 dot (mark 1 unit); 010 dash (mark 3 units); 011 letter gap (space 2 units); 100 word gap (space 6 units); 101–111 reserved, treated as END.
- Every dot/dash is followed by an automatic 1-unit space, so letter gap totals 3 units and word gap 7 units.
- States: IDLE, FETCH, MARK, SPACE, DONE.
- IDLE: sel = 0, key_out = 0. start=1 → FETCH.
- FETCH (exactly 1 cycle; mux settles): on exit, decode sym. Dot/dash → MARK with units = 1/3. Letter/word gap → SPACE with units = 2/6, flagged "no auto-gap". END/reserved → DONE.
- MARK: key_out = 1 for units × TICK_DIV cycles, then SPACE with units = 1.
- SPACE: key_out = 0 for units × TICK_DIV cycles; then, if sel = 15 → DONE, else sel ← sel + 1 and → FETCH.
- DONE: 1 cycle, done = 1, sel returns to 0 on exit → IDLE.
- Counters: tick counter (clog2(TICK_DIV) bits) cleared on entry to MARK/SPACE, wraps at TICK_DIV−1 and decrements a 3-bit unit counter; state exits when unit counter reaches 0 at the tick wrap. sel is 4 bits and never wraps; slot 15 is the last slot.

## Timing
- Reset (rst_n = 0, asynchronous): state IDLE, sel = 0, key_out = 0, busy = 0, done = 0, counters 0.
- All outputs are registered; key_out is 1 exactly during MARK cycles.
- start sampled at edge N → FETCH in cycle N+1, busy = 1 from cycle N+1.
- Slot cost: 1 FETCH cycle + (mark units + 1) × TICK_DIV for dot/dash; 1 + gap units × TICK_DIV for gaps.
- start while busy: ignored, no queueing. start and abort in the same cycle in IDLE: abort wins, stays IDLE.
- abort in any state: next edge → IDLE, key_out = 0, sel = 0, no done pulse.
- Reset mid-message: immediate return to reset values, no done pulse.
- sym is only sampled in FETCH; changes to sym in other states have no effect.

## Test plan
- Single dot, TICK_DIV = 4, slots {001, 000}: start → busy high 11 cycles (1 FETCH + 4 MARK + 4 SPACE + 1 FETCH + 1 DONE), key_out high 4 cycles starting 2 cycles after start edge, done pulse in the 11th busy cycle, sel 0→1→0.
- "SOS" {001,001,001,011,010,010,010,011,001,001,001,000}: key_out high pulses of 4,4,4,12,12,12,4,4,4 cycles; low gaps of 4 (+1 FETCH) within letters, 12 (+2 FETCH) between letters; done once.
- All 16 slots dot (001), no END: sel reaches 15, DONE entered after slot 15's auto-gap, sel never shows 0 again until DONE exit; 16 mark pulses.
- Reserved code 110 in slot 2 after two dots: exactly 2 mark pulses then DONE; done = 1 for one cycle.
- abort asserted in the middle of a dash: key_out = 0, busy = 0, sel = 0 on the next cycle, no done; subsequent start runs a full message normally.
- rst_n pulsed low during MARK and start asserted while busy: reset forces all outputs to 0 asynchronously; start during busy produces no restart or extra pulse.
